// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deframe and fold F0/E0 prefixes into key events.
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56750
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]        ckSync_q, dSync_q;
  logic [FILTER-1:0] filt_q;
  logic              ckF_q, ckF_d;
  logic              fall_q, fall_d;
  logic              filtAllLo, filtAllHi, bitIn;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic              par_q, par_d;
  logic              brk_q, brk_d, ex_q, ex_d;
  logic [7:0]        code_q, code_d;
  logic              make_q, make_d, ext_q, ext_d;
  logic              strb_q, strb_d, err_q, err_d;

  assign filtAllLo = (filt_q == '0);
  assign filtAllHi = &filt_q;
  assign ckF_d     = filtAllLo ? 1'b0 : (filtAllHi ? 1'b1 : ckF_q);
  assign fall_d    = ckF_q & filtAllLo;
  assign bitIn     = dSync_q[1];

  // Front end resets to an idle-high line so no spurious fall follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ckSync_q <= 2'b11;
      dSync_q  <= 2'b11;
      filt_q   <= '1;
      ckF_q    <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      ckSync_q <= {ckSync_q[0], ps2Ck};
      dSync_q  <= {dSync_q[0], ps2D};
      filt_q   <= {filt_q[FILTER-2:0], ckSync_q[1]};
      ckF_q    <= ckF_d;
      fall_q   <= fall_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      ex_q    <= 1'b0;
      code_q  <= 8'h00;
      make_q  <= 1'b0;
      ext_q   <= 1'b0;
      strb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      ex_q    <= ex_d;
      code_q  <= code_d;
      make_q  <= make_d;
      ext_q   <= ext_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
    end
  end

`ifdef PS2_WATCHDOG_EN
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  logic [15:0] wdog_q, wdog_d;

  assign wdog_d = (state_q == IDLE || fall_q) ? 16'd0 : wdog_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wdog_q <= 16'd0;
    else       wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    brk_d   = brk_q;
    ex_d    = ex_q;
    code_d  = code_q;
    make_d  = make_q;
    ext_d   = ext_q;
    strb_d  = 1'b0;
    err_d   = 1'b0;
    if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!bitIn) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end
        end
        DATA: begin
          sh_d  = {bitIn, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bitIn;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bitIn && (^{sh_q, par_q})) begin
            if (sh_q == 8'hF0)      brk_d = 1'b1;
            else if (sh_q == 8'hE0) ex_d  = 1'b1;
            else begin
              code_d = sh_q;
              make_d = !brk_q;
              ext_d  = ex_q;
              strb_d = 1'b1;
              brk_d  = 1'b0;
              ex_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ex_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_WATCHDOG_EN
    // A stalled frame is abandoned silently; a coincident fall takes precedence.
    else if (state_q != IDLE && wdog_q == TimeoutVal) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      brk_d   = 1'b0;
      ex_d    = 1'b0;
    end
`endif
  end

  assign strb = strb_q;
  assign make = make_q;
  assign code = code_q;
  assign ext  = ext_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table of frames plus hand-written latency, glitch and reset sequences.
// Define PS2_WATCHDOG_EN to also exercise the truncated-frame watchdog.
module tb_ps2_kbd_rx;

  localparam int FILT = 8;
  localparam int TO   = 600;
  localparam int HALF = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Ck = 1'b1;
  logic       ps2D  = 1'b1;
  logic       strb, make, ext, err;
  logic [7:0] code;

  int total = 0;
  int bad   = 0;
  int strbCnt = 0;
  int errCnt  = 0;
  int bothCnt = 0;

  ps2_kbd_rx #(.FILTER(FILT), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2Ck(ps2Ck),
    .ps2D (ps2D),
    .strb (strb),
    .make (make),
    .code (code),
    .ext  (ext),
    .err  (err)
  );

  always #5 clock = ~clock;

  // Event counters sampled away from the active edge.
  always @(negedge clock) begin
    if (strb) strbCnt++;
    if (err) errCnt++;
    if (strb && err) bothCnt++;
  end

  typedef struct {
    logic [7:0] b;
    bit         badPar;
    bit         badStop;
    int         expStrb;
    int         expErr;
    logic [7:0] expCode;
    logic       expMake;
    logic       expExt;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic v, input bit glitch);
    ps2D = v;
    repeat (HALF / 2) @(negedge clock);
    if (glitch) begin
      ps2Ck = 1'b0;
      repeat (3) @(negedge clock);
      ps2Ck = 1'b1;
    end
    repeat (HALF / 2) @(negedge clock);
    ps2Ck = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2Ck = 1'b1;
  endtask

  function automatic logic [10:0] frameBits(input logic [7:0] b, input bit badPar, input bit badStop);
    logic p;
    p = (~^b) ^ badPar;
    return {~badStop, p, b, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input bit glitch);
    logic [10:0] bits;
    bits = frameBits(b, badPar, badStop);
    if (glitch) begin
      repeat (10) @(negedge clock);
      ps2Ck = 1'b0;
      repeat (3) @(negedge clock);
      ps2Ck = 1'b1;
    end
    for (int i = 0; i < 11; i++) sendBit(bits[i], glitch);
    ps2D = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    int s0, e0, n;
    bit found;
    logic [10:0] fb;

    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1'b1, 1'b0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[5]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1'b0, 1'b1};
    vecs[6]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1'b1, 1'b0};
    vecs[7]  = '{8'h1C, 1, 0, 0, 1, 8'h75, 1'b1, 1'b0};
    vecs[8]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1'b1, 1'b0};
    vecs[9]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[10] = '{8'hAA, 1, 0, 0, 1, 8'h1C, 1'b1, 1'b0};
    vecs[11] = '{8'h5A, 0, 0, 1, 0, 8'h5A, 1'b1, 1'b0};
    vecs[12] = '{8'hFF, 0, 0, 1, 0, 8'hFF, 1'b1, 1'b0};
    vecs[13] = '{8'h00, 0, 0, 1, 0, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{8'h1C, 0, 1, 0, 1, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{8'hF0, 0, 0, 0, 0, 8'h00, 1'b1, 1'b0};
    vecs[16] = '{8'h33, 0, 1, 0, 1, 8'h00, 1'b1, 1'b0};
    vecs[17] = '{8'hE1, 0, 0, 1, 0, 8'hE1, 1'b1, 1'b0};

    repeat (5) @(negedge clock);
    checkOutput("rstStrb", int'(strb), 0);
    checkOutput("rstErr",  int'(err),  0);
    checkOutput("rstMake", int'(make), 0);
    checkOutput("rstExt",  int'(ext),  0);
    checkOutput("rstCode", int'(code), 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    checkOutput("idleNoStrb", strbCnt, 0);

    for (int v = 0; v < 18; v++) begin
      s0 = strbCnt;
      e0 = errCnt;
      applyStimulus(vecs[v].b, vecs[v].badPar, vecs[v].badStop, 1'b0);
      checkOutput($sformatf("v%0d_strb", v), strbCnt - s0, vecs[v].expStrb);
      checkOutput($sformatf("v%0d_err", v),  errCnt - e0,  vecs[v].expErr);
      checkOutput($sformatf("v%0d_code", v), int'(code), int'(vecs[v].expCode));
      checkOutput($sformatf("v%0d_make", v), int'(make), int'(vecs[v].expMake));
      checkOutput($sformatf("v%0d_ext", v),  int'(ext),  int'(vecs[v].expExt));
    end

    // Raw stop-bit falling edge to strb: 2 sync + FILTER + 1 to fall, then 1 more.
    fb = frameBits(8'h29, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) sendBit(fb[i], 1'b0);
    ps2D = 1'b1;
    repeat (HALF) @(negedge clock);
    ps2Ck = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (strb) found = 1'b1;
    end
    checkOutput("latency", n, FILT + 4);
    @(negedge clock);
    checkOutput("strbWidth", int'(strb), 0);
    checkOutput("latCode", int'(code), 8'h29);
    repeat (HALF) @(negedge clock);
    ps2Ck = 1'b1;
    repeat (20) @(negedge clock);

    s0 = strbCnt;
    e0 = errCnt;
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1);
    checkOutput("glitchStrb", strbCnt - s0, 1);
    checkOutput("glitchErr",  errCnt - e0,  0);
    checkOutput("glitchCode", int'(code), 8'h1C);

    // Reset in the middle of a frame after a make event.
    fb = frameBits(8'h75, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sendBit(fb[i], 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midRstCode", int'(code), 0);
    checkOutput("midRstMake", int'(make), 0);
    ps2Ck = 1'b1;
    ps2D  = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    s0 = strbCnt;
    e0 = errCnt;
    applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
    checkOutput("postRstStrb", strbCnt - s0, 1);
    checkOutput("postRstErr",  errCnt - e0,  0);
    checkOutput("postRstCode", int'(code), 8'h29);
    checkOutput("postRstMake", int'(make), 1);

`ifdef PS2_WATCHDOG_EN
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    fb = frameBits(8'h75, 1'b0, 1'b0);
    s0 = strbCnt;
    e0 = errCnt;
    for (int i = 0; i < 4; i++) sendBit(fb[i], 1'b0);
    ps2D = 1'b1;
    repeat (2 * TO) @(negedge clock);
    applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
    checkOutput("wdogStrb", strbCnt - s0, 1);
    checkOutput("wdogErr",  errCnt - e0,  0);
    checkOutput("wdogCode", int'(code), 8'h29);
`endif

    checkOutput("strbErrOverlap", bothCnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
